// File: rtl/pc_sequencer.sv
// Fetch-stage PC register: advances by STEP, or redirects on exception/jump/branch; 1-cycle latency.
// Stall holds the PC and drops same-cycle redirects; only an exception overrides a stall.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned      CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [WIDTH-1:0]     branch_target,
  input  logic                 jump_valid,
  input  logic [WIDTH-1:0]     jump_target,
  input  logic                 exc_valid,
  output logic [WIDTH-1:0]     pc,
  output logic [WIDTH-1:0]     pc_plus,
  output logic                 wrap,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] adv_count
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // STEP is a power of two, so the low log2(STEP) bits must be zero; STEP=1 gives an empty mask.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  typedef enum logic [2:0] {
    ACT_EXC,
    ACT_HOLD,
    ACT_JUMP,
    ACT_BRANCH,
    ACT_SEQ
  } act_e;

  act_e                 act;
  logic [WIDTH-1:0]     redirect_target;
  logic                 target_misaligned;

  logic [WIDTH-1:0]     pc_d, pc_q;
  logic [WIDTH-1:0]     pc_plus_d, pc_plus_q;
  logic                 wrap_d, wrap_q;
  logic                 misalign_d, misalign_q;
  logic [CNT_WIDTH-1:0] adv_count_d, adv_count_q;

  always_comb begin
    act = ACT_SEQ;
    if (exc_valid) begin
      act = ACT_EXC;
    end else if (stall) begin
      act = ACT_HOLD;
    end else if (jump_valid) begin
      act = ACT_JUMP;
    end else if (branch_valid) begin
      act = ACT_BRANCH;
    end
    redirect_target   = jump_valid ? jump_target : branch_target;
    target_misaligned = |(redirect_target & ALIGN_MASK);
  end

  always_comb begin
    pc_d        = pc_q;
    wrap_d      = 1'b0;
    misalign_d  = 1'b0;
    adv_count_d = adv_count_q;
    case (act)
      ACT_EXC: begin
        pc_d        = EXC_VECTOR;
        adv_count_d = adv_count_q + CNT_WIDTH'(1);
      end
      ACT_HOLD: begin
        pc_d = pc_q;
      end
      ACT_JUMP, ACT_BRANCH: begin
        if (target_misaligned) begin
          pc_d       = EXC_VECTOR;
          misalign_d = 1'b1;
        end else begin
          pc_d = redirect_target;
        end
        adv_count_d = adv_count_q + CNT_WIDTH'(1);
      end
      default: begin
        // pc_plus_q already holds pc_q + STEP; it is smaller than pc_q only on carry-out.
        pc_d        = pc_plus_q;
        wrap_d      = (pc_plus_q < pc_q);
        adv_count_d = adv_count_q + CNT_WIDTH'(1);
      end
    endcase
    pc_plus_d = pc_d + STEP_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_VECTOR;
      pc_plus_q   <= RESET_VECTOR + STEP_W;
      wrap_q      <= 1'b0;
      misalign_q  <= 1'b0;
      adv_count_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_plus_q   <= pc_plus_d;
      wrap_q      <= wrap_d;
      misalign_q  <= misalign_d;
      adv_count_q <= adv_count_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus   = pc_plus_q;
  assign wrap      = wrap_q;
  assign misalign  = misalign_q;
  assign adv_count = adv_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three parameter sets checked each cycle against an arithmetic model,
// plus directed literal expectations.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i[3];
  logic        stall_i[3];
  logic        bv_i[3];
  logic        jv_i[3];
  logic        ev_i[3];
  logic [31:0] bt_i[3];
  logic [31:0] jt_i[3];

  logic [31:0] pc0, pp0, pc1, pp1;
  logic [15:0] pc2, pp2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  logic        wr0, wr1, wr2, ms0, ms1, ms2;

  pc_sequencer u0 (
    .clk(clk), .rst(rst_i[0]), .stall(stall_i[0]),
    .branch_valid(bv_i[0]), .branch_target(bt_i[0]),
    .jump_valid(jv_i[0]), .jump_target(jt_i[0]), .exc_valid(ev_i[0]),
    .pc(pc0), .pc_plus(pp0), .wrap(wr0), .misalign(ms0), .adv_count(cnt0)
  );

  pc_sequencer #(.STEP(1)) u1 (
    .clk(clk), .rst(rst_i[1]), .stall(stall_i[1]),
    .branch_valid(bv_i[1]), .branch_target(bt_i[1]),
    .jump_valid(jv_i[1]), .jump_target(jt_i[1]), .exc_valid(ev_i[1]),
    .pc(pc1), .pc_plus(pp1), .wrap(wr1), .misalign(ms1), .adv_count(cnt1)
  );

  pc_sequencer #(.WIDTH(16), .STEP(2), .RESET_VECTOR(16'h0000), .EXC_VECTOR(16'h0080),
                 .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst_i[2]), .stall(stall_i[2]),
    .branch_valid(bv_i[2]), .branch_target(bt_i[2][15:0]),
    .jump_valid(jv_i[2]), .jump_target(jt_i[2][15:0]), .exc_valid(ev_i[2]),
    .pc(pc2), .pc_plus(pp2), .wrap(wr2), .misalign(ms2), .adv_count(cnt2)
  );

  logic [63:0] a_pc[3], a_pp[3], a_cnt[3];
  logic        a_wr[3], a_ms[3];
  assign a_pc[0]  = {32'b0, pc0};
  assign a_pc[1]  = {32'b0, pc1};
  assign a_pc[2]  = {48'b0, pc2};
  assign a_pp[0]  = {32'b0, pp0};
  assign a_pp[1]  = {32'b0, pp1};
  assign a_pp[2]  = {48'b0, pp2};
  assign a_cnt[0] = {48'b0, cnt0};
  assign a_cnt[1] = {48'b0, cnt1};
  assign a_cnt[2] = {62'b0, cnt2};
  assign a_wr[0] = wr0;
  assign a_wr[1] = wr1;
  assign a_wr[2] = wr2;
  assign a_ms[0] = ms0;
  assign a_ms[1] = ms1;
  assign a_ms[2] = ms2;

  int unsigned     pw[3]  = '{32, 32, 16};
  int unsigned     ps[3]  = '{4, 1, 2};
  int unsigned     pcw[3] = '{16, 16, 2};
  longint unsigned rv[3]  = '{64'h0, 64'h0, 64'h0};
  longint unsigned evv[3] = '{64'h80, 64'h80, 64'h80};

  longint unsigned m_pc[3];
  longint unsigned m_cnt[3];
  bit              m_wrap[3];
  bit              m_mis[3];
  bit              m_valid[3] = '{1'b0, 1'b0, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", i, nm, act, exp, $time);
    end
  endtask

  // Model: what the PC must become, from the action rules, using plain modular arithmetic.
  task automatic model_step(input int i);
    longint unsigned mask  = (64'd1 << pw[i]) - 64'd1;
    longint unsigned cmask = (64'd1 << pcw[i]) - 64'd1;
    longint unsigned t, s;
    if (rst_i[i]) begin
      m_pc[i] = rv[i]; m_cnt[i] = 0; m_wrap[i] = 0; m_mis[i] = 0; m_valid[i] = 1;
    end else if (m_valid[i]) begin
      m_wrap[i] = 0;
      m_mis[i]  = 0;
      if (ev_i[i]) begin
        m_pc[i]  = evv[i];
        m_cnt[i] = (m_cnt[i] + 1) & cmask;
      end else if (!stall_i[i]) begin
        if (jv_i[i] || bv_i[i]) begin
          t = jv_i[i] ? {32'b0, jt_i[i]} : {32'b0, bt_i[i]};
          t = t & mask;
          if ((t % ps[i]) != 0) begin
            m_pc[i]  = evv[i];
            m_mis[i] = 1;
          end else begin
            m_pc[i] = t;
          end
        end else begin
          s = m_pc[i] + ps[i];
          m_wrap[i] = (s > mask);
          m_pc[i]   = s & mask;
        end
        m_cnt[i] = (m_cnt[i] + 1) & cmask;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (m_valid[k]) begin
        chk(k, "pc", a_pc[k], m_pc[k]);
        chk(k, "pc_plus", a_pp[k], (m_pc[k] + ps[k]) & ((64'd1 << pw[k]) - 64'd1));
        chk(k, "wrap", {63'b0, a_wr[k]}, {63'b0, m_wrap[k]});
        chk(k, "misalign", {63'b0, a_ms[k]}, {63'b0, m_mis[k]});
        chk(k, "adv_count", a_cnt[k], m_cnt[k]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int i);
    stall_i[i] = 0; bv_i[i] = 0; jv_i[i] = 0; ev_i[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_i[i] = 1; idle(i); bt_i[i] = '0; jt_i[i] = '0;
    end
    tick(2);
    chk(0, "reset pc", a_pc[0], 64'h0);
    chk(0, "reset pc_plus", a_pp[0], 64'h4);
    chk(0, "reset cnt", a_cnt[0], 64'h0);
    chk(0, "reset flags", {62'b0, a_wr[0], a_ms[0]}, 64'h0);

    // Free run
    rst_i[0] = 0;
    tick(1);
    chk(0, "run pc1", a_pc[0], 64'h4);
    tick(2);
    chk(0, "run pcC", a_pc[0], 64'hC);
    chk(0, "run cnt3", a_cnt[0], 64'h3);

    // Wrap
    bv_i[0] = 1; bt_i[0] = 32'hFFFF_FFFC;
    tick(1);
    chk(0, "br top pc", a_pc[0], 64'hFFFF_FFFC);
    chk(0, "br top pc_plus", a_pp[0], 64'h0);
    idle(0);
    tick(1);
    chk(0, "wrap pc", a_pc[0], 64'h0);
    chk(0, "wrap pc_plus", a_pp[0], 64'h4);
    chk(0, "wrap set", {63'b0, a_wr[0]}, 64'h1);
    tick(1);
    chk(0, "wrap clear", {63'b0, a_wr[0]}, 64'h0);

    // Stall drops branch
    jv_i[0] = 1; jt_i[0] = 32'h10;
    tick(1);
    idle(0);
    stall_i[0] = 1; bv_i[0] = 1; bt_i[0] = 32'h100;
    tick(3);
    chk(0, "stall pc", a_pc[0], 64'h10);
    idle(0);
    tick(1);
    chk(0, "post-stall pc", a_pc[0], 64'h14);

    // Priority
    jv_i[0] = 1; jt_i[0] = 32'h200; bv_i[0] = 1; bt_i[0] = 32'h300;
    tick(1);
    chk(0, "jump over branch", a_pc[0], 64'h200);
    ev_i[0] = 1; stall_i[0] = 1;
    tick(1);
    chk(0, "exc over stall", a_pc[0], 64'h80);
    idle(0);

    // Misalign
    bv_i[0] = 1; bt_i[0] = 32'h102;
    tick(1);
    chk(0, "misalign pc", a_pc[0], 64'h80);
    chk(0, "misalign set", {63'b0, a_ms[0]}, 64'h1);
    idle(0);
    tick(1);
    chk(0, "misalign clear", {63'b0, a_ms[0]}, 64'h0);
    jv_i[0] = 1; jt_i[0] = 32'h203; bv_i[0] = 1; bt_i[0] = 32'h400;
    tick(1);
    chk(0, "bad jump + good branch", {63'b0, a_ms[0]}, 64'h1);
    idle(0);
    tick(1);

    // Reset mid-run
    jv_i[0] = 1; jt_i[0] = 32'h44;
    tick(1);
    chk(0, "pc 44", a_pc[0], 64'h44);
    idle(0);
    rst_i[0] = 1;
    tick(1);
    chk(0, "midrst pc", a_pc[0], 64'h0);
    chk(0, "midrst cnt", a_cnt[0], 64'h0);
    rst_i[0] = 0;
    tick(1);

    // Held stall
    stall_i[0] = 1;
    tick(5);
    chk(0, "held stall pc", a_pc[0], 64'h4);
    idle(0);
    rst_i[0] = 1;

    // STEP=1: odd targets are legal
    rst_i[1] = 0;
    bv_i[1] = 1; bt_i[1] = 32'h102;
    tick(1);
    chk(1, "step1 pc", a_pc[1], 64'h102);
    chk(1, "step1 pc_plus", a_pp[1], 64'h103);
    chk(1, "step1 misalign", {63'b0, a_ms[1]}, 64'h0);
    idle(1);
    tick(1);
    rst_i[1] = 1;

    // WIDTH=16 STEP=2 CNT_WIDTH=2
    rst_i[2] = 0;
    tick(2);
    chk(2, "w16 cnt2", a_cnt[2], 64'h2);
    jv_i[2] = 1; jt_i[2] = 32'h0000_FFFE;
    tick(1);
    chk(2, "w16 pc", a_pc[2], 64'hFFFE);
    chk(2, "w16 cnt3", a_cnt[2], 64'h3);
    idle(2);
    tick(1);
    chk(2, "w16 wrap pc", a_pc[2], 64'h0);
    chk(2, "w16 wrap", {63'b0, a_wr[2]}, 64'h1);
    chk(2, "w16 cnt roll", a_cnt[2], 64'h0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the MIPS datapath, replacing the stand-alone combinational PC incrementer. Holds the architectural PC in a register and advances it by a configurable step each cycle. Applies stalls and branch, jump and exception redirects under a fixed priority, and reports wrap-around and misaligned-target faults. Sits at the front of the fetch stage and drives the instruction-memory address and the PC+step value used by the link/branch logic.

## Interface
- `WIDTH`, 32, PC width in bits.
- `STEP`, 4, increment per advance; must be a power of two, ≥ 1.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_0080, PC loaded on exception or misaligned target.
- `CNT_WIDTH`, 16, width of the advance counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC (ignored when `exc_valid`=1).
- `branch_valid`  in  1  load `branch_target` this cycle.
- `branch_target`  in  WIDTH  branch destination.
- `jump_valid`  in  1  load `jump_target` this cycle.
- `jump_target`  in  WIDTH  jump destination.
- `exc_valid`  in  1  load `EXC_VECTOR` this cycle.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus`  out  WIDTH  `pc + STEP` mod 2^WIDTH (registered, always consistent with `pc`).
- `wrap`  out  1  one-cycle pulse: the last sequential advance overflowed.
- `misalign`  out  1  one-cycle pulse: the last redirect target was misaligned.
- `adv_count`  out  CNT_WIDTH  number of PC updates since reset; wraps modulo 2^CNT_WIDTH.

## Operation
- Each cycle, evaluate the first matching action, highest priority first:
  1. `rst`
  2. `exc_valid`
  3. `stall`
  4. `jump_valid`
  5. `branch_valid`
  6. sequential advance
- `rst`:
  - `pc`=RESET_VECTOR, `pc_plus`=RESET_VECTOR+STEP.
  - `wrap`=0, `misalign`=0, `adv_count`=0.
- `exc_valid`: `pc`←EXC_VECTOR and `adv_count`+1. This applies even when `stall`=1.
- `stall` (no exception):
  - `pc`, `pc_plus` and `adv_count` hold.
  - `jump_valid` and `branch_valid` are dropped; upstream re-presents them after the stall.
- Jump wins over branch when both are asserted.
- Redirect target check: a target is misaligned if `target[log2(STEP)-1:0]` ≠ 0 (never when STEP=1).
  - Aligned target: `pc`←target.
  - Misaligned target: `pc`←EXC_VECTOR and `misalign`=1 next cycle.
  - `adv_count`+1 in both cases.
- Sequential advance: `pc`←`pc_plus`, `adv_count`+1.
  - If `pc + STEP` carries out of WIDTH bits, the result wraps modulo 2^WIDTH and `wrap`=1 next cycle.
- `pc_plus` is always recomputed from the new `pc` on the same edge, with WIDTH-bit wrapping arithmetic.
- `wrap` and `misalign` are cleared on every edge that does not set them, including stall cycles.
- `adv_count` wraps from all-ones to 0 with no flag.

## Timing
- Latency: a redirect or advance requested in cycle N is visible on `pc` and `pc_plus` after the edge ending cycle N (one cycle).
- `pc`, `pc_plus` and the flags are all registered; there is no combinational path from inputs to outputs.
- Reset mid-operation: `rst` asserted in any cycle overrides every other input at that edge; the outputs take their reset values the next cycle.
- After reset, the first edge with `rst`=0 and no stall yields `pc`=RESET_VECTOR+STEP.
- Simultaneous events:
  - `exc_valid` + `stall` + `jump_valid`: exception taken.
  - `jump_valid` + `branch_valid` with a misaligned jump target: fault raised even if the branch target is aligned.
- Held stall: `pc` stays stable indefinitely; `wrap` and `misalign` read 0.

## Test plan
- Reset then free-run (defaults): `rst`=1 for 2 cycles, then release → `pc` = 0x0, 0x4, 0x8, 0xC on successive cycles; `adv_count`=3 at `pc`=0xC.
- Wrap: branch to 0xFFFF_FFFC, then advance → `pc`=0x0, `pc_plus`=0x4, `wrap`=1 for exactly one cycle.
- Stall and drop:
  - Stall at `pc`=0x10 for 3 cycles with `branch_valid`=1 (target 0x100) during the stall → `pc` stays 0x10 and the branch is ignored.
  - After release → `pc`=0x14.
- Priority:
  - `jump_valid` (0x200) and `branch_valid` (0x300) together → `pc`=0x200.
  - `exc_valid` with `stall`=1 and `jump_valid`=1 → `pc`=0x80.
- Misalign: branch target 0x102 → `pc`=0x80 and `misalign`=1 for one cycle; with `STEP`=1 the same target → `pc`=0x102 and `misalign`=0.
- Reset mid-run / parameters:
  - `rst` at `pc`=0x44 → `pc`=0x0, `adv_count`=0 next cycle.
  - With `WIDTH`=16, `STEP`=2, `CNT_WIDTH`=2, advancing from 0xFFFE → `pc`=0x0 with `wrap`=1, and `adv_count` rolls 3→0.
